// File: rtl/mcycle_pkg.sv
// Shared opcode encodings, FSM states and opcode decode helpers for the multi-cycle mul/div unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcycle_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mcycle_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
// Latency: n/a (wires only).
// Backpressure: Busy from the unit stalls the requester.
interface mcycle_if #(parameter int WIDTH = 32);

    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );

endinterface

// File: rtl/mcycle_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module mcycle_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Multiply: acc = {partial high, remaining multiplier bits}; add then shift right.
    // Divide:   acc = {partial remainder, dividend bits / quotient bits}; shift left then trial subtract.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial    = shifted - {1'b0, operand};
        acc_next = {add_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (trial[WIDTH]) begin
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mcycle_unit.sv
// Iterative RV32M-style multiply/divide beside the ALU; operands latched on Start.
// Latency: WIDTH cycles from the Start edge to the Done pulse; one op per WIDTH+1 cycles.
// Backpressure: Busy high while computing; Start ignored until the DONE cycle.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     CLK,
    input  logic     RESETn,
    mcycle_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   dividend_q;
    logic               is_div_q;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   result1_q;
    logic [WIDTH-1:0]   result2_q;
    logic               busy_q;
    logic               done_q;

    logic               sgn_in;
    logic               div_in;
    logic [WIDTH-1:0]   mag1_in;
    logic [WIDTH-1:0]   mag2_in;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_r1;
    logic [WIDTH-1:0]   fin_r2;
    logic               last_iter;

    always_comb begin
        sgn_in  = op_is_signed(bus.MCycleOp);
        div_in  = op_is_div(bus.MCycleOp);
        mag1_in = (sgn_in && bus.Operand1[WIDTH-1]) ? -bus.Operand1 : bus.Operand1;
        mag2_in = (sgn_in && bus.Operand2[WIDTH-1]) ? -bus.Operand2 : bus.Operand2;
    end

    mcycle_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd_q),
        .is_div   (is_div_q),
        .acc_next (acc_next)
    );

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Sign fix-up on the final accumulator; MIN / -1 needs no special case since
    // the magnitude quotient 2^(WIDTH-1) negates back onto itself.
    always_comb begin
        prod   = neg_res ? -acc_next : acc_next;
        fin_r1 = prod[WIDTH-1:0];
        fin_r2 = prod[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            if (div_zero) begin
                fin_r1 = '1;
                fin_r2 = dividend_q;
            end else begin
                fin_r1 = neg_res ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
                fin_r2 = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            acc        <= '0;
            opnd_q     <= '0;
            dividend_q <= '0;
            is_div_q   <= 1'b0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            div_zero   <= 1'b0;
            result1_q  <= '0;
            result2_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        state      <= S_COMPUTE;
                        busy_q     <= 1'b1;
                        cnt        <= '0;
                        is_div_q   <= div_in;
                        dividend_q <= bus.Operand1;
                        neg_res    <= sgn_in & (bus.Operand1[WIDTH-1] ^ bus.Operand2[WIDTH-1]);
                        neg_rem    <= sgn_in & bus.Operand1[WIDTH-1];
                        div_zero   <= (bus.Operand2 == '0);
                        // Divide walks the dividend through the low half; multiply walks the multiplier.
                        acc        <= {{WIDTH{1'b0}}, div_in ? mag1_in : mag2_in};
                        opnd_q     <= div_in ? mag2_in : mag1_in;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_COMPUTE: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        state     <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        result1_q <= fin_r1;
                        result2_q <= fin_r2;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Result1 = result1_q;
    assign bus.Result2 = result2_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;

endmodule
